// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter that sequences word accesses to the data memory.
// Each access takes one arbitration cycle (IDLE) followed by one service cycle (SERVE).
module dm_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [31:0]       pc0,
    input  logic [31:0]       pc1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [31:0]       mem_pc,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_id
);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t            state_reg;
    logic              prio_reg;
    logic              g_id_reg;
    logic              g_we_reg;
    logic [ADDR_W-1:0] g_addr_reg;
    logic [DATA_W-1:0] g_wdata_reg;
    logic [31:0]       g_pc_reg;

    logic any_req;
    logic sel;
    logic serving;
    logic misalign;

    // A lone requester always wins; prio only breaks ties.
    always_comb begin
        any_req = req0 | req1;
        sel     = (req0 & req1) ? prio_reg : req1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            prio_reg    <= 1'b0;
            g_id_reg    <= 1'b0;
            g_we_reg    <= 1'b0;
            g_addr_reg  <= '0;
            g_wdata_reg <= '0;
            g_pc_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        g_id_reg    <= sel;
                        g_we_reg    <= sel ? we1 : we0;
                        g_addr_reg  <= sel ? addr1 : addr0;
                        g_wdata_reg <= sel ? wdata1 : wdata0;
                        g_pc_reg    <= sel ? pc1 : pc0;
                        prio_reg    <= ~sel;
                        state_reg   <= SERVE;
                    end
                end
                SERVE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by reset so an interrupted SERVE cycle never half-commits.
    always_comb begin
        serving   = (state_reg == SERVE);
        misalign  = (g_addr_reg[1:0] != 2'b00);
        busy      = serving;
        gnt_id    = serving & g_id_reg;
        mem_addr  = serving ? g_addr_reg : '0;
        mem_wdata = serving ? g_wdata_reg : '0;
        mem_pc    = serving ? g_pc_reg : '0;
        mem_we    = serving & g_we_reg & ~misalign & ~reset;
        ack0      = serving & ~g_id_reg & ~reset;
        ack1      = serving & g_id_reg & ~reset;
        err0      = ack0 & misalign;
        err1      = ack1 & misalign;
        rdata0    = (serving & ~g_id_reg) ? mem_rdata : '0;
        rdata1    = (serving & g_id_reg) ? mem_rdata : '0;
    end

endmodule
